// File: rtl/tick_gen_pkg.sv
// Shared types and defaults for the multi-channel tick generator.
// Channel state encoding plus the reset period used when no override is given.
package tick_gen_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } chan_state_t;

    localparam int TICK_DEFAULT_PERIOD = 2**21 - 1;

endpackage

// File: rtl/tick_chan.sv
// One tick channel: counts 0..P-1 while running and pulses tick combinationally on the last count.
// Tick appears P cycles after the accepting edge; no backpressure, commands are sampled every cycle.
module tick_chan
    import tick_gen_pkg::*;
#(
    parameter int WIDTH          = 21,
    parameter int DEFAULT_PERIOD = TICK_DEFAULT_PERIOD
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             stop,
    input  logic             oneshot,
    input  logic             wr_vld,
    input  logic [WIDTH-1:0] wr_dat,
    output logic             tick,
    output logic             busy
);

    localparam logic [WIDTH-1:0] DEF_P = WIDTH'(DEFAULT_PERIOD);
    localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);

    chan_state_t      state_q, state_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] per_q, per_d;
    logic [WIDTH-1:0] pend_q;
    logic             mode_q, mode_d;
    logic             at_end;

    // per_q is never zero, so per_q-1 cannot underflow.
    assign at_end = (cnt_q == (per_q - ONE));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            per_q   <= DEF_P;
            pend_q  <= DEF_P;
            mode_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            per_q   <= per_d;
            mode_q  <= mode_d;
            if (wr_vld) begin
                pend_q <= wr_dat;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        per_d   = per_q;
        mode_d  = mode_q;
        tick    = (state_q == RUN) && at_end;

        unique case (state_q)
            IDLE: begin
                if (start && !stop) begin
                    state_d = RUN;
                    cnt_d   = '0;
                    per_d   = pend_q;
                    mode_d  = oneshot;
                end
            end
            RUN: begin
                if (stop) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (start) begin
                    cnt_d  = '0;
                    per_d  = pend_q;
                    mode_d = oneshot;
                end else if (at_end) begin
                    // Wrap point: a one-shot retires, a periodic run picks up the pending period.
                    cnt_d = '0;
                    if (mode_q) begin
                        state_d = IDLE;
                    end else begin
                        per_d = pend_q;
                    end
                end else begin
                    cnt_d = cnt_q + ONE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign busy = (state_q == RUN);

endmodule

// File: rtl/tick_gen.sv
// Multi-channel tick generator: decodes period loads and flags rejected ones one cycle later.
// Ticks are combinational from each channel; no backpressure, every input is sampled each cycle.
module tick_gen
    import tick_gen_pkg::*;
#(
    parameter int WIDTH          = 21,
    parameter int CHANNELS       = 4,
    parameter int DEFAULT_PERIOD = TICK_DEFAULT_PERIOD
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [CHANNELS-1:0]         start,
    input  logic [CHANNELS-1:0]         stop,
    input  logic [CHANNELS-1:0]         oneshot,
    input  logic                        load,
    input  logic [$clog2(CHANNELS)-1:0] load_ch,
    input  logic [WIDTH-1:0]            load_val,
    output logic [CHANNELS-1:0]         tick,
    output logic [CHANNELS-1:0]         busy,
    output logic                        load_err
);

    localparam int CH_W = $clog2(CHANNELS);

    logic ch_ok;
    logic val_ok;
    logic load_ok;
    logic [CHANNELS-1:0] wr_vld;

    assign ch_ok   = (32'(load_ch) < 32'(CHANNELS));
    assign val_ok  = |load_val;
    assign load_ok = load && ch_ok && val_ok;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            load_err <= 1'b0;
        end else begin
            load_err <= load && !load_ok;
        end
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
        assign wr_vld[i] = load_ok && (load_ch == CH_W'(i));

        tick_chan #(
            .WIDTH          (WIDTH),
            .DEFAULT_PERIOD (DEFAULT_PERIOD)
        ) u_chan (
            .clk     (clk),
            .reset   (reset),
            .start   (start[i]),
            .stop    (stop[i]),
            .oneshot (oneshot[i]),
            .wr_vld  (wr_vld[i]),
            .wr_dat  (load_val),
            .tick    (tick[i]),
            .busy    (busy[i])
        );
    end

endmodule

// File: tb/tb_tick_gen.sv
// Scoreboard bench for tick_gen: stimulus queues expected tick/load_err events, a negedge monitor checks them.
module tb_tick_gen;

    localparam int WIDTH    = 4;
    localparam int CHANNELS = 4;
    localparam int DEF      = 8;
    localparam int ERR_SRC  = CHANNELS;

    logic                clk      = 1'b0;
    logic                reset    = 1'b0;
    logic [CHANNELS-1:0] start    = '0;
    logic [CHANNELS-1:0] stop     = '0;
    logic [CHANNELS-1:0] oneshot  = '0;
    logic                load     = 1'b0;
    logic [1:0]          load_ch  = '0;
    logic [WIDTH-1:0]    load_val = '0;
    logic [CHANNELS-1:0] tick;
    logic [CHANNELS-1:0] busy;
    logic                load_err;

    typedef struct {
        int src;
        int edge_n;
    } ev_t;

    ev_t exp_q[$];
    int  cyc        = 0;
    int  compared   = 0;
    int  mismatched = 0;

    tick_gen #(
        .WIDTH          (WIDTH),
        .CHANNELS       (CHANNELS),
        .DEFAULT_PERIOD (DEF)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .stop     (stop),
        .oneshot  (oneshot),
        .load     (load),
        .load_ch  (load_ch),
        .load_val (load_val),
        .tick     (tick),
        .busy     (busy),
        .load_err (load_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Events are tagged with the rising edge that would capture them.
    always @(negedge clk) begin
        bit   v;
        ev_t  e;
        for (int s = 0; s <= CHANNELS; s++) begin
            v = (s < CHANNELS) ? tick[s] : load_err;
            if (v) begin
                compared++;
                if (exp_q.size() == 0) begin
                    mismatched++;
                    $display("FAIL unexpected_event: src %0d at edge %0d, none expected", s, cyc + 1);
                end else begin
                    e = exp_q.pop_front();
                    if (e.src != s || e.edge_n != cyc + 1) begin
                        mismatched++;
                        $display("FAIL event_order: got src %0d at edge %0d, expected src %0d at edge %0d",
                                 s, cyc + 1, e.src, e.edge_n);
                    end
                end
            end
        end
    end

    task automatic check(string name, int act, int exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic push(int src, int e);
        exp_q.push_back('{src, e});
    endtask

    task automatic drained(string name);
        compared++;
        if (exp_q.size() != 0) begin
            mismatched++;
            $display("FAIL %s: %0d expected events never seen, first src %0d edge %0d, required 0 pending",
                     name, exp_q.size(), exp_q[0].src, exp_q[0].edge_n);
        end
        exp_q.delete();
    endtask

    task automatic go(int e);
        while (cyc < e) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_start(int ch, bit os, output int a);
        a = cyc + 1;
        start[ch]   = 1'b1;
        oneshot[ch] = os;
        @(posedge clk);
        #1;
        start[ch]   = 1'b0;
        oneshot[ch] = 1'b0;
    endtask

    task automatic do_stop(int ch);
        stop[ch] = 1'b1;
        @(posedge clk);
        #1;
        stop[ch] = 1'b0;
    endtask

    task automatic do_both(int ch);
        start[ch] = 1'b1;
        stop[ch]  = 1'b1;
        @(posedge clk);
        #1;
        start[ch] = 1'b0;
        stop[ch]  = 1'b0;
    endtask

    task automatic do_load(int ch, int val, output int l);
        l        = cyc + 1;
        load     = 1'b1;
        load_ch  = 2'(ch);
        load_val = WIDTH'(val);
        @(posedge clk);
        #1;
        load     = 1'b0;
        load_ch  = '0;
        load_val = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        int a;
        int l;

        // Reset state, checked while reset is held low.
        #12;
        check("reset_tick", int'(tick), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_load_err", int'(load_err), 0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;

        // Periodic ch0 at the default period of 8.
        do_start(0, 1'b0, a);
        push(0, a + 8);
        push(0, a + 16);
        push(0, a + 24);
        go(a + 1);
        check("p0_busy_early", int'(busy[0]), 1);
        go(a + 12);
        check("p0_busy_mid", int'(busy[0]), 1);
        go(a + 24);
        check("p0_busy_late", int'(busy[0]), 1);
        go(a + 25);
        do_stop(0);
        go(a + 28);
        check("p0_busy_after_stop", int'(busy[0]), 0);
        drained("p0_periodic_drain");

        // One-shot on ch1 with period 3.
        do_load(1, 3, l);
        do_start(1, 1'b1, a);
        push(1, a + 3);
        go(a + 2);
        check("os1_busy_running", int'(busy[1]), 1);
        go(a + 3);
        check("os1_busy_fall", int'(busy[1]), 0);
        go(a + 23);
        drained("os1_oneshot_drain");

        // Mid-run load on ch0: current period finishes at 8, then period 2.
        do_start(0, 1'b0, a);
        push(0, a + 8);
        push(0, a + 10);
        push(0, a + 12);
        push(0, a + 14);
        go(a + 3);
        do_load(0, 2, l);
        go(a + 14);
        do_stop(0);
        go(a + 18);
        drained("midload_drain");

        // Start and stop together on a running ch2: stop wins.
        do_start(2, 1'b0, a);
        go(a + 2);
        do_both(2);
        check("both_busy", int'(busy[2]), 0);
        check("both_tick", int'(tick[2]), 0);
        go(a + 12);
        drained("both_drain");

        // Zero-period load on ch3 is rejected; ch3 keeps period 8.
        push(ERR_SRC, cyc + 2);
        do_load(3, 0, l);
        go(l + 2);
        check("load_err_single", int'(load_err), 0);
        do_start(3, 1'b0, a);
        push(3, a + 8);
        go(a + 8);
        do_stop(3);
        go(a + 12);
        drained("zero_load_drain");

        // Reset mid-run on ch3 at count 5; ch0 period returns to default.
        do_start(3, 1'b0, a);
        go(a + 5);
        check("pre_reset_busy", int'(busy[3]), 1);
        reset = 1'b0;
        #1;
        check("async_reset_busy", int'(busy), 0);
        check("async_reset_tick", int'(tick), 0);
        check("async_reset_err", int'(load_err), 0);
        go(a + 8);
        reset = 1'b1;
        @(posedge clk);
        #1;
        do_start(0, 1'b0, a);
        push(0, a + 8);
        go(a + 8);
        do_stop(0);
        go(a + 12);
        drained("post_reset_drain");

        // Period 1 on ch1: tick every cycle until the stop edge.
        do_load(1, 1, l);
        do_start(1, 1'b0, a);
        for (int k = 1; k <= 10; k++) push(1, a + k);
        go(a + 9);
        do_stop(1);
        check("p1_tick_after_stop", int'(tick[1]), 0);
        check("p1_busy_after_stop", int'(busy[1]), 0);
        go(a + 13);
        drained("p1_drain");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
